// File: rtl/pc_npc_unit_pkg.sv
// Shared definitions for the SPARC V8 PC/nPC pair: next-nPC source encodings,
// word width, sequential increment and the word-alignment helper.
package pc_npc_unit_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'b00,
    NPC_DISP = 2'b01,
    NPC_JMPL = 2'b10,
    NPC_RSVD = 2'b11
  } npc_sel_e;

  function automatic logic word_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-nPC target selection: sequential, PC-relative (branch/CALL)
// or register-indirect (JMPL/RETT), plus the word-alignment check on the result.
module pc_target_mux
  import pc_npc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] npc,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] disp_in,
  input  logic [31:0] jmpl_target,
  output logic [31:0] target,
  output logic        target_ok
);

  logic [WORD_W-1:0] target_s;

  // Select the candidate target; the reserved encoding behaves as sequential.
  always_comb begin
    target_s = npc + PC_INC;
    case (npc_sel_e'(npc_sel))
      NPC_SEQ:  target_s = npc + PC_INC;
      NPC_DISP: target_s = pc + disp_in;
      NPC_JMPL: target_s = jmpl_target;
      NPC_RSVD: target_s = npc + PC_INC;
      default:  target_s = npc + PC_INC;
    endcase
  end

  assign target    = target_s;
  assign target_ok = word_aligned(target_s);

endmodule

// File: rtl/pc_npc_unit.sv
// PC/nPC register pair with delayed control transfer, delay-slot annul flag,
// sticky misalignment flag and PC/nPC capture on trap entry.
module pc_npc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] disp_in,
  input  logic [31:0] jmpl_target,
  input  logic        annul_req,
  input  logic        trap_req,
  input  logic [31:0] trap_vector,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        annul,
  output logic        misaligned,
  output logic [31:0] saved_pc,
  output logic [31:0] saved_npc
);
  import pc_npc_unit_pkg::*;

  logic [WORD_W-1:0] pc_r, npc_r, saved_pc_r, saved_npc_r;
  logic              annul_r, misaligned_r;
  logic [WORD_W-1:0] target_s;
  logic              target_ok_s;

  pc_target_mux u_target_mux (
    .pc          (pc_r),
    .npc         (npc_r),
    .npc_sel     (npc_sel),
    .disp_in     (disp_in),
    .jmpl_target (jmpl_target),
    .target      (target_s),
    .target_ok   (target_ok_s)
  );

  // State update: trap entry outranks advance; a misaligned target blocks the step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r         <= RESET_PC;
      npc_r        <= RESET_PC + PC_INC;
      annul_r      <= 1'b0;
      misaligned_r <= 1'b0;
      saved_pc_r   <= 32'h0000_0000;
      saved_npc_r  <= 32'h0000_0000;
    end else if (trap_req) begin
      saved_pc_r   <= pc_r;
      saved_npc_r  <= npc_r;
      pc_r         <= trap_vector;
      npc_r        <= trap_vector + PC_INC;
      annul_r      <= 1'b0;
      misaligned_r <= 1'b0;
    end else if (advance && target_ok_s) begin
      pc_r    <= npc_r;
      npc_r   <= target_s;
      annul_r <= annul_req;
    end else if (advance) begin
      misaligned_r <= 1'b1;
    end
  end

  assign pc         = pc_r;
  assign npc        = npc_r;
  assign annul      = annul_r;
  assign misaligned = misaligned_r;
  assign saved_pc   = saved_pc_r;
  assign saved_npc  = saved_npc_r;

endmodule

// File: tb/tb_pc_npc_unit.sv
// Scoreboard bench for pc_npc_unit: directed scenarios plus random stimulus,
// expected state from an architectural model, compared by a separate monitor.
module tb_pc_npc_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        annul;
    logic        mis;
    logic [31:0] spc;
    logic [31:0] snpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        advance = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic [31:0] disp_in = 32'h0;
  logic [31:0] jmpl_target = 32'h0;
  logic        annul_req = 1'b0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_vector = 32'h0;
  logic [31:0] pc, npc, saved_pc, saved_npc;
  logic        annul, misaligned;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t m;
  exp_t mon_e;

  pc_npc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .advance     (advance),
    .npc_sel     (npc_sel),
    .disp_in     (disp_in),
    .jmpl_target (jmpl_target),
    .annul_req   (annul_req),
    .trap_req    (trap_req),
    .trap_vector (trap_vector),
    .pc          (pc),
    .npc         (npc),
    .annul       (annul),
    .misaligned  (misaligned),
    .saved_pc    (saved_pc),
    .saved_npc   (saved_npc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m.pc = 32'h0; m.npc = 32'h4; m.annul = 1'b0; m.mis = 1'b0;
    m.spc = 32'h0; m.snpc = 32'h0;
  endtask

  // Architectural reference: delayed transfer, trap priority, sticky misalignment.
  task automatic model_step(input logic adv, input logic trp, input logic [1:0] sel,
                            input logic [31:0] d, input logic [31:0] j,
                            input logic [31:0] tv, input logic ar);
    logic [31:0] t;
    if (trp) begin
      m.spc = m.pc; m.snpc = m.npc;
      m.pc = tv; m.npc = tv + 32'd4;
      m.annul = 1'b0; m.mis = 1'b0;
    end else if (adv) begin
      if (sel == 2'b01)      t = m.pc + d;
      else if (sel == 2'b10) t = j;
      else                   t = m.npc + 32'd4;
      if (t % 4 != 0) m.mis = 1'b1;
      else begin
        m.pc = m.npc; m.npc = t; m.annul = ar;
      end
    end
  endtask

  task automatic step(input logic adv, input logic trp, input logic [1:0] sel,
                      input logic [31:0] d, input logic [31:0] j,
                      input logic [31:0] tv, input logic ar);
    @(negedge clk);
    advance = adv; trap_req = trp; npc_sel = sel; disp_in = d;
    jmpl_target = j; trap_vector = tv; annul_req = ar;
    @(posedge clk);
    #1;
    model_step(adv, trp, sel, d, j, tv, ar);
    q.push_back(m);
  endtask

  task automatic check_now(input string tag);
    chk({tag, ".pc"}, pc, m.pc);
    chk({tag, ".npc"}, npc, m.npc);
    chk({tag, ".annul"}, {31'd0, annul}, {31'd0, m.annul});
    chk({tag, ".mis"}, {31'd0, misaligned}, {31'd0, m.mis});
    chk({tag, ".spc"}, saved_pc, m.spc);
    chk({tag, ".snpc"}, saved_npc, m.snpc);
  endtask

  // Monitor: registered outputs are compared against the scoreboard away from the edge.
  always @(negedge clk) begin
    if (reset_n && q.size() > 0) begin
      mon_e = q.pop_front();
      chk("mon.pc", pc, mon_e.pc);
      chk("mon.npc", npc, mon_e.npc);
      chk("mon.annul", {31'd0, annul}, {31'd0, mon_e.annul});
      chk("mon.misaligned", {31'd0, misaligned}, {31'd0, mon_e.mis});
      chk("mon.saved_pc", saved_pc, mon_e.spc);
      chk("mon.saved_npc", saved_npc, mon_e.snpc);
    end
  end

  initial begin
    logic [31:0] d, j, tv;
    logic [1:0]  sel;
    model_reset();
    #12;
    check_now("reset");
    @(negedge clk);
    reset_n = 1'b1;

    repeat (3) step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 2'b01, 32'h40, 32'h0, 32'h0, 1'b0);

    step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h100, 1'b0);
    step(1'b1, 1'b0, 2'b01, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);

    step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h200, 1'b0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);

    step(1'b1, 1'b0, 2'b10, 32'h0, 32'h3002, 32'h0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h70, 1'b0);

    step(1'b1, 1'b1, 2'b01, 32'h8, 32'h0, 32'h800, 1'b1);
    step(1'b1, 1'b0, 2'b11, 32'h0, 32'h0, 32'h0, 1'b0);

    step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFF8, 1'b0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      sel = 2'($urandom_range(0, 3));
      d   = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 15) == 0) d = d | 32'h2;
      if ($urandom_range(0, 1) == 1) d = d | 32'hFFFF_0000;
      j   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) j = j | 32'(($urandom_range(1, 3)));
      tv  = $urandom & 32'hFFFF_FFF0;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
           sel, d, j, tv, 1'($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    advance = 1'b0; trap_req = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_now("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    chk("drain.queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
